// File: rtl/alu_seq_pkg.sv
// ============================================================================
// alu_seq_pkg : opcode, flag types and helpers shared by the alu_seq block
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_seq_pkg;

  typedef enum logic [4:0] {
    OP_AND = 5'h00, OP_EOR = 5'h01, OP_SUB = 5'h02, OP_RSB = 5'h03,
    OP_ADD = 5'h04, OP_ADC = 5'h05, OP_SBC = 5'h06, OP_RSC = 5'h07,
    OP_TST = 5'h08, OP_TEQ = 5'h09, OP_CMP = 5'h0A, OP_CMN = 5'h0B,
    OP_ORR = 5'h0C, OP_MOV = 5'h0D, OP_BIC = 5'h0E, OP_MVN = 5'h0F,
    OP_MUL = 5'h10
  } alu_op_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Compare-style ops discard the result but always commit their flags
  function automatic logic is_test_op(input logic [4:0] op);
    return (op >= 5'h08) && (op <= 5'h0B);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq_core.sv
// ============================================================================
// alu_seq_core : combinational single-cycle op unit (legacy 16-op set)
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  alu_op_e          i_op,
  input  logic [WIDTH-1:0] i_rn,
  input  logic [WIDTH-1:0] i_src2,
  input  nzcv_t            i_flags,
  output logic [WIDTH-1:0] o_rd,
  output logic             o_rd_we,
  output nzcv_t            o_flags
);

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_bp;
  logic [WIDTH-1:0] w_logic;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH:0]   w_sum;
  logic             w_cin;
  logic             w_sub;
  logic             w_arith;

  always_comb begin
    w_a     = i_rn;
    w_b     = i_src2;
    w_cin   = 1'b0;
    w_sub   = 1'b0;
    w_arith = 1'b0;
    w_logic = '0;
    case (i_op)
      OP_AND, OP_TST: w_logic = i_rn & i_src2;
      OP_EOR, OP_TEQ: w_logic = i_rn ^ i_src2;
      OP_ORR:         w_logic = i_rn | i_src2;
      OP_MOV:         w_logic = i_src2;
      OP_BIC:         w_logic = i_rn & ~i_src2;
      OP_MVN:         w_logic = ~i_rn;
      OP_ADD, OP_CMN: w_arith = 1'b1;
      OP_ADC: begin
        w_arith = 1'b1;
        w_cin   = i_flags.c;
      end
      OP_SUB, OP_CMP: begin
        w_arith = 1'b1;
        w_sub   = 1'b1;
        w_cin   = 1'b1;
      end
      OP_RSB: begin
        w_arith = 1'b1;
        w_sub   = 1'b1;
        w_cin   = 1'b1;
        w_a     = i_src2;
        w_b     = i_rn;
      end
      OP_SBC: begin
        w_arith = 1'b1;
        w_sub   = 1'b1;
        w_cin   = i_flags.c;
      end
      OP_RSC: begin
        w_arith = 1'b1;
        w_sub   = 1'b1;
        w_cin   = i_flags.c;
        w_a     = i_src2;
        w_b     = i_rn;
      end
      default: w_logic = '0;
    endcase
  end

  // Subtraction is a + ~b + cin, so C=1 means no borrow
  assign w_bp  = w_sub ? ~w_b : w_b;
  assign w_sum = {1'b0, w_a} + {1'b0, w_bp} + {{WIDTH{1'b0}}, w_cin};
  assign w_res = w_arith ? w_sum[WIDTH-1:0] : w_logic;

  assign o_flags.n = w_res[WIDTH-1];
  assign o_flags.z = ~|w_res;
  assign o_flags.c = w_arith ? w_sum[WIDTH] : i_flags.c;
  assign o_flags.v = w_arith ? ((w_a[WIDTH-1] == w_bp[WIDTH-1]) && (w_res[WIDTH-1] != w_a[WIDTH-1]))
                             : i_flags.v;

  assign o_rd_we = ~is_test_op(i_op);
  assign o_rd    = o_rd_we ? w_res : '0;

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// alu_seq : registered ALU with NZCV register, carry-in ops and shift-add MUL
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic             set_flags,
  input  logic [WIDTH-1:0] rn,
  input  logic [WIDTH-1:0] src2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rd,
  output logic             rd_we,
  output logic [3:0]       flags
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplr;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             r_mul_s;
  nzcv_t            r_flags;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_rd;
  logic             r_rd_we;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_pop;
  logic             w_is_mul;
  logic             w_is_legacy;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_core_rd;
  logic             w_core_we;
  nzcv_t            w_core_flags;

  alu_seq_core #(.WIDTH(WIDTH)) u_core (
    .i_op    (alu_op_e'(op)),
    .i_rn    (rn),
    .i_src2  (src2),
    .i_flags (r_flags),
    .o_rd    (w_core_rd),
    .o_rd_we (w_core_we),
    .o_flags (w_core_flags)
  );

  assign w_is_mul    = (op == OP_MUL);
  assign w_is_legacy = ~op[4];
  assign w_accept    = in_valid & w_in_ready;
  assign w_pop       = r_out_valid & out_ready;
  assign w_mul_done  = (r_state == S_MUL) && (r_cnt == CNT_W'(WIDTH - 1));
  assign w_acc_nxt   = r_mplr[0] ? (r_acc + r_mcand) : r_acc;

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = ~rst & (~r_out_valid | out_ready);
        if (in_valid && w_in_ready && w_is_mul) w_state_nxt = S_MUL;
      end
      S_MUL: begin
        if (w_mul_done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_mcand     <= '0;
      r_mplr      <= '0;
      r_acc       <= '0;
      r_mul_s     <= 1'b0;
      r_flags     <= '0;
      r_out_valid <= 1'b0;
      r_rd        <= '0;
      r_rd_we     <= 1'b0;
    end else begin
      // Fixed-length iteration: every multiplier bit is visited, no early exit
      if (r_state == S_MUL) begin
        r_acc   <= w_acc_nxt;
        r_mcand <= r_mcand << 1;
        r_mplr  <= r_mplr >> 1;
        r_cnt   <= r_cnt + CNT_W'(1);
      end
      if (w_accept && w_is_mul) begin
        r_mcand <= rn;
        r_mplr  <= src2;
        r_acc   <= '0;
        r_cnt   <= '0;
        r_mul_s <= set_flags;
      end

      if (w_mul_done) begin
        r_out_valid <= 1'b1;
        r_rd        <= w_acc_nxt;
        r_rd_we     <= 1'b1;
        if (r_mul_s) begin
          r_flags.n <= w_acc_nxt[WIDTH-1];
          r_flags.z <= ~|w_acc_nxt;
        end
      end else if (w_accept && !w_is_mul) begin
        r_out_valid <= 1'b1;
        r_rd        <= w_is_legacy ? w_core_rd : '0;
        r_rd_we     <= w_is_legacy & w_core_we;
        if (w_is_legacy && (set_flags || is_test_op(op))) r_flags <= w_core_flags;
      end else if (w_pop) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign rd        = r_rd;
  assign rd_we     = r_rd_we;
  assign flags     = r_flags;

endmodule

`default_nettype wire
